udp_tx_sched: RTL and testbench
===============================

# udp_tx_sched

Multi-channel UDP transmit scheduler between N frame producers (camera, status, debug) and the single RMII UDP/MAC transmit engine. Each channel requests a frame with a byte length. The block arbitrates round-robin, hands the engine one frame at a time, and steers payload bytes from the granted channel. It owns the IPv4 identification counter in the clock domain with a synchronous update, and inserts a programmable inter-frame gap.

## Interface
Parameters:
- CH_NUM, 4: number of producer channels (1..8).
- LEN_W, 16: length field width.
- MAX_LEN, 1472: largest accepted payload length in bytes.
- IDENT_INIT, 16'h0123: IPv4 identification value after reset.
- GAP_CYC, 12: idle cycles after each frame before the next grant (0 allowed).
- BUSY_TO, 255: cycles to wait for engine busy to rise before aborting.

Ports:
- clk in 1: 50 MHz RMII clock.
- rst in 1: synchronous, active-high reset.
- I_req in CH_NUM: per-channel frame request, level; held until grant.
- I_len in CH_NUM*LEN_W: packed per-channel payload length; channel k uses bits [k*LEN_W +: LEN_W].
- I_data in CH_NUM*8: packed per-channel payload byte.
- O_grant out CH_NUM: one-hot; high from the START state through the SEND state.
- O_rd out CH_NUM: per-channel byte-consumed strobe.
- O_err out CH_NUM: one-cycle error pulse per channel.
- I_mac_ready in 1: PHY/SMI init done.
- I_mac_busy in 1: engine busy.
- I_mac_isLoadData in 1: engine consumes one payload byte this cycle.
- O_mac_en out 1: frame start pulse.
- O_mac_data out 8: payload byte to engine.
- O_mac_len out 16: payload length to engine.
- O_mac_ipv4sign out 16: identification for current frame.
- O_busy out 1: high when the state is anything other than IDLE.

## Operation
- States: IDLE, START, WAIT_BUSY, SEND, GAP.
- IDLE:
  - Requires I_mac_ready=1 and any I_req bit set.
  - Chooses the winner: the first requesting channel at or after ptr+1, mod CH_NUM.
  - Winner length 0 or >MAX_LEN: O_err[winner] pulses, ptr←winner, stay in IDLE.
  - Otherwise, register O_grant, O_mac_len (zero-extended to 16 bits) and ptr←winner, then go to START.
- START: O_mac_en=1 for exactly one cycle, then WAIT_BUSY.
- WAIT_BUSY:
  - I_mac_busy=1 → SEND.
  - BUSY_TO cycles without busy: O_err[granted] pulses, grant drops, go to GAP. The ident counter does not advance.
- SEND:
  - O_mac_data = I_data of the granted channel, combinational mux.
  - O_rd = O_grant & {CH_NUM{I_mac_isLoadData}}.
  - Byte counter increments on every I_mac_isLoadData.
  - I_mac_busy falls → ident+1 (16-bit wrap FFFF→0000).
  - If the byte count ≠ O_mac_len at that falling edge, O_err[granted] pulses in the same cycle.
  - Grant drops, go to GAP.
- GAP: counts GAP_CYC cycles; when GAP_CYC=0 it takes one cycle. Then IDLE.
- O_mac_len, O_mac_ipv4sign and O_grant are stable from START until leaving SEND.
- I_req changes during a frame are ignored until IDLE.
- I_mac_ready falling mid-frame: the frame completes normally; no new grant is issued.
- Reset values:
  - State IDLE.
  - O_grant, O_rd, O_err, O_mac_en, O_mac_data, O_mac_len all 0.
  - O_mac_ipv4sign = IDENT_INIT.
  - ptr = CH_NUM-1, so channel 0 wins first.
  - O_busy = 0.
- Reset mid-frame: same values on the next edge. The engine sees O_mac_en low and is responsible for its own abort.

## Timing
- Request seen in IDLE at edge T:
  - O_grant and O_mac_len valid after T+1.
  - O_mac_en high during cycle T+1 only.
  - O_busy high from T+1.
- Error pulse for a bad length appears in cycle T+1. The next arbitration is possible from T+1.
- Data path SEND: zero latency. O_rd is in the same cycle as I_mac_isLoadData, and the producer advances its byte on the following edge.
- Busy falling edge at T: ident updated and grant low at T+1. The next O_mac_en occurs no earlier than T+1+GAP_CYC+2.
- Ident increments once per completed frame, not per error.

## Configuration
- UDP_TX_PRIO_EN defined: channel 0 has strict priority. Whenever I_req[0]=1 in IDLE, channel 0 wins regardless of ptr. Channels 1..CH_NUM-1 round-robin among themselves, and ptr is not updated by channel 0 grants.
- Undefined: pure round-robin over all channels as described above.

## Test plan
- Reset, then I_req=4'b0001 with len=100, engine model busy 3 cycles after en and 100 load strobes → O_mac_en single pulse, O_mac_len=100, O_mac_ipv4sign=0x0123 during the frame, 100 O_rd[0] strobes, ident=0x0124 after.
- I_req=4'b1111 held, all len=10 → grant order 0,1,2,3,0. Consecutive O_mac_en pulses are at least GAP_CYC+2 cycles after busy falls.
- I_len[1]=0, then I_len[1]=1473 → O_err[1] single-cycle pulse each time, no O_mac_en, ident unchanged.
- Engine never raises busy → O_err pulse after 255 cycles in WAIT_BUSY, grant drops, ident unchanged, the next channel is served.
- Preload ident to 0xFFFF via IDENT_INIT override and send one frame → ident 0x0000. Then assert rst mid-SEND → all outputs return to reset values on the next edge and ident returns to IDENT_INIT.
- With UDP_TX_PRIO_EN, I_req=4'b1110 then channel 0 asserts during channel 1's frame → channel 0 wins the next slot, then channel 2.

Source files
------------

// File: rtl/udp_tx_sched.sv
// udp_tx_sched: schedules UDP frames from CH_NUM producers onto one MAC
// transmit engine. Round-robin arbitration, length checking, busy-rise
// timeout, IPv4 identification counter and a programmable inter-frame gap.
// Optional feature macro: UDP_TX_PRIO_EN (channel 0 gets strict priority).
module udp_tx_sched #(
  parameter int          CH_NUM     = 4,
  parameter int          LEN_W      = 16,
  parameter int          MAX_LEN    = 1472,
  parameter logic [15:0] IDENT_INIT = 16'h0123,
  parameter int          GAP_CYC    = 12,
  parameter int          BUSY_TO    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CH_NUM-1:0]       I_req,
  input  logic [CH_NUM*LEN_W-1:0] I_len,
  input  logic [CH_NUM*8-1:0]     I_data,
  output logic [CH_NUM-1:0]       O_grant,
  output logic [CH_NUM-1:0]       O_rd,
  output logic [CH_NUM-1:0]       O_err,
  input  logic                    I_mac_ready,
  input  logic                    I_mac_busy,
  input  logic                    I_mac_isLoadData,
  output logic                    O_mac_en,
  output logic [7:0]              O_mac_data,
  output logic [15:0]             O_mac_len,
  output logic [15:0]             O_mac_ipv4sign,
  output logic                    O_busy
);

  localparam int PTR_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  // One bit wider than the 16-bit length so a runaway byte count cannot
  // wrap back onto a valid length; also holds the timeout and gap counts.
  localparam int CNT_W = 17;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_SEND      = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  localparam logic [LEN_W-1:0] L_MAX_LEN = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] L_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_TO_LAST = CNT_W'(BUSY_TO - 1);
  localparam logic [CNT_W-1:0] L_GAP_LAST = CNT_W'(GAP_CYC - 1);

  logic [2:0]        r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_sel;
  logic [CH_NUM-1:0] r_grant;
  logic [CH_NUM-1:0] r_err;
  logic              r_en;
  logic [15:0]       r_len;
  logic [15:0]       r_ident;
  logic [CNT_W-1:0]  r_cnt;

  logic [CH_NUM-1:0] w_req_rr;
  logic              w_found;
  logic [PTR_W-1:0]  w_win;
  logic [PTR_W-1:0]  w_ptr_next;
  logic [CH_NUM-1:0] w_win_oh;
  logic [LEN_W-1:0]  w_win_len;
  logic              w_len_bad;
  logic [CNT_W-1:0]  w_bytes;

  // Arbitration: first requester at or after ptr+1 (mod CH_NUM) wins.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // otherwise an unassigned path would infer a latch.
    w_found = 1'b0;
    w_win   = '0;
`ifdef UDP_TX_PRIO_EN
    w_req_rr = I_req & ~CH_NUM'(1);
`else
    w_req_rr = I_req;
`endif
    for (int i = 1; i <= CH_NUM; i++) begin
      if (!w_found && w_req_rr[(int'(r_ptr) + i) % CH_NUM]) begin
        w_found = 1'b1;
        w_win   = PTR_W'((int'(r_ptr) + i) % CH_NUM);
      end
    end
`ifdef UDP_TX_PRIO_EN
    // Channel 0 overrides the rotation and leaves the pointer untouched.
    if (I_req[0]) begin
      w_found = 1'b1;
      w_win   = '0;
    end
    w_ptr_next = I_req[0] ? r_ptr : w_win;
`else
    w_ptr_next = w_win;
`endif
    w_win_oh        = '0;
    w_win_oh[w_win] = 1'b1;
    w_win_len       = I_len[int'(w_win)*LEN_W +: LEN_W];
    w_len_bad       = (w_win_len == '0) || (w_win_len > L_MAX_LEN);
  end

  // Byte count including a strobe arriving in the current cycle.
  assign w_bytes = r_cnt + {{(CNT_W-1){1'b0}}, I_mac_isLoadData};

  // Frame sequencing FSM with its counters and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= PTR_W'(CH_NUM - 1);
      r_sel   <= '0;
      r_grant <= '0;
      r_err   <= '0;
      r_en    <= 1'b0;
      r_len   <= '0;
      r_ident <= IDENT_INIT;
      r_cnt   <= '0;
    end else begin
      r_en  <= 1'b0;
      r_err <= '0;
      case (r_state)
        S_IDLE: begin
          if (I_mac_ready && w_found) begin
            r_ptr <= w_ptr_next;
            if (w_len_bad) begin
              r_err <= w_win_oh;
            end else begin
              r_grant <= w_win_oh;
              r_sel   <= w_win;
              r_len   <= 16'(w_win_len);
              r_en    <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_START;
            end
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (I_mac_busy) begin
            r_cnt   <= '0;
            r_state <= S_SEND;
          end else if (r_cnt == L_TO_LAST) begin
            r_err   <= r_grant;
            r_grant <= '0;
            r_cnt   <= '0;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + L_CNT_ONE;
          end
        end
        S_SEND: begin
          if (!I_mac_busy) begin
            r_ident <= r_ident + 16'd1;
            if (w_bytes != {1'b0, r_len}) r_err <= r_grant;
            r_grant <= '0;
            r_cnt   <= '0;
            r_state <= S_GAP;
          end else begin
            r_cnt <= w_bytes;
          end
        end
        S_GAP: begin
          if (GAP_CYC == 0 || r_cnt >= L_GAP_LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + L_CNT_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Zero-latency payload path from the granted producer to the engine.
  always_comb begin
    O_mac_data = 8'h00;
    O_rd       = '0;
    if (r_state == S_SEND) begin
      O_mac_data = I_data[int'(r_sel)*8 +: 8];
      O_rd       = r_grant & {CH_NUM{I_mac_isLoadData}};
    end
  end

  assign O_grant        = r_grant;
  assign O_err          = r_err;
  assign O_mac_en       = r_en;
  assign O_mac_len      = r_len;
  assign O_mac_ipv4sign = r_ident;
  assign O_busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_udp_tx_sched.sv
// tb_udp_tx_sched: scoreboard bench for udp_tx_sched. Expected frames are
// queued as requests are raised and popped when the DUT starts a frame.
// A second instance with IDENT_INIT=16'hFFFF shares all stimulus to cover
// the identification wrap.
`timescale 1ns/1ps
module tb_udp_tx_sched;
  localparam int CH  = 4;
  localparam int LW  = 16;
  localparam int GAP = 12;
  localparam int BTO = 255;

  typedef struct {
    int          ch;
    int          len;
    logic [15:0] ident;
  } exp_t;

  logic clk;
  logic rst;
  logic [CH-1:0]    I_req;
  logic [CH*LW-1:0] I_len;
  logic [CH*8-1:0]  I_data;
  logic I_mac_ready, I_mac_busy, I_mac_isLoadData;

  logic [CH-1:0] m_grant, m_rd, m_err, x_grant, x_rd, x_err;
  logic          m_en, m_busy, x_en, x_busy;
  logic [7:0]    m_data, x_data;
  logic [15:0]   m_len, m_ident, x_len, x_ident;

  exp_t        sb[$];
  logic [15:0] exp_ident;
  int          n_checks;
  int          n_pass;
  int          cyc;
  int          t_fall;

  udp_tx_sched u_dut (
    .clk(clk), .rst(rst), .I_req(I_req), .I_len(I_len), .I_data(I_data),
    .O_grant(m_grant), .O_rd(m_rd), .O_err(m_err),
    .I_mac_ready(I_mac_ready), .I_mac_busy(I_mac_busy),
    .I_mac_isLoadData(I_mac_isLoadData),
    .O_mac_en(m_en), .O_mac_data(m_data), .O_mac_len(m_len),
    .O_mac_ipv4sign(m_ident), .O_busy(m_busy)
  );

  udp_tx_sched #(.IDENT_INIT(16'hFFFF)) u_wrap (
    .clk(clk), .rst(rst), .I_req(I_req), .I_len(I_len), .I_data(I_data),
    .O_grant(x_grant), .O_rd(x_rd), .O_err(x_err),
    .I_mac_ready(I_mac_ready), .I_mac_busy(I_mac_busy),
    .I_mac_isLoadData(I_mac_isLoadData),
    .O_mac_en(x_en), .O_mac_data(x_data), .O_mac_len(x_len),
    .O_mac_ipv4sign(x_ident), .O_busy(x_busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int ch, input int len);
    I_len[ch*LW +: LW] = LW'(len);
  endtask

  task automatic push_frame(input int ch, input int len, input bit completes);
    sb.push_back('{ch, len, exp_ident});
    if (completes) exp_ident = exp_ident + 16'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    I_req = '0;
    I_mac_busy = 1'b0;
    I_mac_isLoadData = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_ident = 16'h0123;
    sb.delete();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    check("idle_reached", m_busy, 0);
  endtask

  // Engine model: waits for a frame start, checks it against the scoreboard,
  // then raises busy and issues nbytes load strobes (or never raises busy).
  task automatic engine(input bit drop_req, input bit raise, input int nbytes, input bit gap_chk);
    exp_t e;
    int n, bad, rdc;
    logic [CH-1:0] oh;
    n = 0;
    while (m_en !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("en_seen", m_en, 1);
    if (m_en !== 1'b1) return;
    if (gap_chk) check("gap_min", (cyc - t_fall) >= GAP + 2, 1);
    check("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    oh = CH'(1) << e.ch;
    check("grant", m_grant, oh);
    check("mac_len", m_len, e.len);
    check("ident", m_ident, e.ident);
    check("busy_out", m_busy, 1);
    if (drop_req) I_req[e.ch] = 1'b0;
    tick();
    check("en_pulse", m_en, 0);
    if (!raise) begin
      repeat (BTO - 1) tick();
      check("to_early", {m_grant, m_err}, {oh, CH'(0)});
      tick();
      check("to_err", m_err, oh);
      check("to_grant", m_grant, 0);
      check("to_ident", m_ident, e.ident);
      tick();
      check("to_err_pulse", m_err, 0);
      return;
    end
    repeat (2) tick();
    I_mac_busy = 1'b1;
    tick();
    bad = 0;
    rdc = 0;
    for (int i = 0; i < nbytes; i++) begin
      I_data[e.ch*8 +: 8] = 8'(i*7 + e.ch);
      I_mac_isLoadData = 1'b1;
      #1;
      if (m_data !== 8'(i*7 + e.ch)) bad++;
      if (m_grant !== oh || m_len !== 16'(e.len) || m_ident !== e.ident) bad++;
      if (m_rd === oh) rdc++;
      tick();
    end
    I_mac_isLoadData = 1'b0;
    #1;
    check("rd_idle", m_rd, 0);
    check("data_mux", bad, 0);
    check("rd_count", rdc, nbytes);
    I_mac_busy = 1'b0;
    t_fall = cyc;
    tick();
    check("done_grant", m_grant, 0);
    check("done_ident", m_ident, 16'(e.ident + 16'd1));
    check("len_err", m_err, (nbytes == e.len) ? CH'(0) : oh);
    tick();
    check("err_clear", m_err, 0);
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_pass = 0;
    cyc = 0;
    t_fall = 0;
    I_len = '0;
    I_data = '0;
    I_mac_ready = 1'b0;
    do_reset();

    // Reset values.
    check("rst_grant", m_grant, 0);
    check("rst_err", m_err, 0);
    check("rst_rd", m_rd, 0);
    check("rst_en", m_en, 0);
    check("rst_len", m_len, 0);
    check("rst_data", m_data, 0);
    check("rst_ident", m_ident, 16'h0123);
    check("rst_busy", m_busy, 0);
    check("rst_wrap_ident", x_ident, 16'hFFFF);

    // Ready low blocks grants.
    I_mac_ready = 1'b0;
    set_len(0, 100);
    I_req = 4'b0001;
    repeat (3) tick();
    check("not_ready_busy", m_busy, 0);
    I_mac_ready = 1'b1;

    // Single 100-byte frame from channel 0.
    push_frame(0, 100, 1);
    engine(1, 1, 100, 0);
    check("wrap_ident", x_ident, 16'h0000);

    // Round-robin over four held requests.
    do_reset();
    for (int k = 0; k < CH; k++) set_len(k, 10);
    push_frame(0, 10, 1);
    push_frame(1, 10, 1);
    push_frame(2, 10, 1);
    push_frame(3, 10, 1);
    push_frame(0, 10, 1);
    I_req = 4'b1111;
    engine(0, 1, 10, 0);
    for (int k = 0; k < 4; k++) engine(0, 1, 10, 1);
    I_req = '0;

    // Bad lengths: zero and MAX_LEN+1.
    wait_idle();
    set_len(1, 0);
    I_req = 4'b0010;
    tick();
    check("len0_err", m_err, 4'b0010);
    check("len0_en", m_en, 0);
    I_req = '0;
    tick();
    check("len0_pulse", m_err, 0);
    check("len0_busy", m_busy, 0);
    set_len(1, 1473);
    I_req = 4'b0010;
    tick();
    check("lenmax_err", m_err, 4'b0010);
    check("lenmax_en", m_en, 0);
    I_req = '0;
    tick();
    check("lenmax_pulse", m_err, 0);
    check("len_ident", m_ident, exp_ident);

    // Busy timeout on channel 2, then channel 1 at exactly MAX_LEN.
    set_len(1, 1472);
    set_len(2, 10);
    push_frame(2, 10, 0);
    push_frame(1, 1472, 1);
    I_req = 4'b0110;
    engine(0, 0, 0, 0);
    I_req[2] = 1'b0;
    engine(1, 1, 1472, 0);

    // Short frame: one byte missing gives an error with the grant drop.
    set_len(3, 10);
    push_frame(3, 10, 1);
    I_req = 4'b1000;
    engine(1, 1, 9, 0);

    // Channel 0 arrives while channel 1 is being served.
    wait_idle();
    do_reset();
    set_len(1, 10);
    push_frame(1, 10, 1);
    I_req = 4'b1110;
    tick();
    I_req[0] = 1'b1;
`ifdef UDP_TX_PRIO_EN
    push_frame(0, 10, 1);
    push_frame(2, 10, 1);
    for (int k = 0; k < 3; k++) engine(1, 1, 10, 0);
`else
    push_frame(2, 10, 1);
    push_frame(3, 10, 1);
    push_frame(0, 10, 1);
    for (int k = 0; k < 4; k++) engine(1, 1, 10, 0);
`endif
    I_req = '0;

    // Reset in the middle of SEND.
    wait_idle();
    set_len(0, 50);
    I_req = 4'b0001;
    n = 0;
    while (m_en !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("mid_en_seen", m_en, 1);
    I_req = '0;
    tick();
    I_mac_busy = 1'b1;
    tick();
    tick();
    I_data[7:0] = 8'h5A;
    I_mac_isLoadData = 1'b1;
    #1;
    check("mid_rd", m_rd, 4'b0001);
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_grant", m_grant, 0);
    check("mid_rst_rd", m_rd, 0);
    check("mid_rst_err", m_err, 0);
    check("mid_rst_en", m_en, 0);
    check("mid_rst_data", m_data, 0);
    check("mid_rst_len", m_len, 0);
    check("mid_rst_ident", m_ident, 16'h0123);
    check("mid_rst_busy", m_busy, 0);
    check("mid_rst_wrap_ident", x_ident, 16'hFFFF);
    rst = 1'b0;
    I_mac_busy = 1'b0;
    I_mac_isLoadData = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
